// File: rtl/dsram_req_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// dsram_req_ctrl_pkg
// Shared definitions for the data-SRAM request controller:
//   - bus field widths (address, data, byte strobes, size)
//   - access size encodings SZ_B / SZ_H / SZ_W
//   - request FSM state codes
//   - helpers building byte strobes and lane-replicated store data
// ---------------------------------------------------------------------------
package dsram_req_ctrl_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int SIZE_W = 2;

  localparam logic [SIZE_W-1:0] SZ_B = 2'd0;
  localparam logic [SIZE_W-1:0] SZ_H = 2'd1;
  localparam logic [SIZE_W-1:0] SZ_W = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

  // Loads never drive strobes. Size 3 is illegal and falls into the word case.
  function automatic logic [STRB_W-1:0] gen_wstrb(input logic              wr,
                                                  input logic [SIZE_W-1:0] size,
                                                  input logic [1:0]        addr_lo);
    logic [STRB_W-1:0] strb;
    if (!wr) begin
      strb = '0;
    end else begin
      case (size)
        SZ_B:    strb = 4'b0001 << addr_lo;
        SZ_H:    strb = 4'b0011 << {addr_lo[1], 1'b0};
        default: strb = 4'hf;
      endcase
    end
    return strb;
  endfunction

  // Right-justified store data copied onto every lane so the strobes pick it.
  function automatic logic [DATA_W-1:0] gen_wdata(input logic [SIZE_W-1:0] size,
                                                  input logic [DATA_W-1:0] data);
    logic [DATA_W-1:0] rep;
    case (size)
      SZ_B:    rep = {4{data[7:0]}};
      SZ_H:    rep = {2{data[15:0]}};
      default: rep = data;
    endcase
    return rep;
  endfunction

endpackage

// File: rtl/dsram_req_ctrl_if.sv
// ---------------------------------------------------------------------------
// Interfaces of the data-SRAM request controller.
//
// dsram_pipe_if : pipeline side (EXE requests, MEM responses, flush)
//   master = pipeline, slave = controller
//   req_valid/req_ready/req_wr/req_size/req_addr/req_wdata : request handshake
//   flush                                                  : cancel everything
//   resp_valid/resp_ready/resp_wr/resp_rdata               : in-order responses
//
// dsram_sram_if : SRAM-like bus (req / addr_ok / data_ok)
//   master = controller, slave = memory
//   data_sram_req/wr/size/wstrb/addr/wdata : address phase
//   data_sram_addr_ok                      : address phase accepted
//   data_sram_data_ok/data_sram_rdata      : in-order data phase
// ---------------------------------------------------------------------------
interface dsram_pipe_if;
  import dsram_req_ctrl_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [SIZE_W-1:0] req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              flush;
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_wr;
  logic [DATA_W-1:0] resp_rdata;

  modport master (
    output req_valid, req_wr, req_size, req_addr, req_wdata, flush, resp_ready,
    input  req_ready, resp_valid, resp_wr, resp_rdata
  );

  modport slave (
    input  req_valid, req_wr, req_size, req_addr, req_wdata, flush, resp_ready,
    output req_ready, resp_valid, resp_wr, resp_rdata
  );
endinterface

interface dsram_sram_if;
  import dsram_req_ctrl_pkg::*;

  logic              data_sram_req;
  logic              data_sram_wr;
  logic [SIZE_W-1:0] data_sram_size;
  logic [STRB_W-1:0] data_sram_wstrb;
  logic [ADDR_W-1:0] data_sram_addr;
  logic [DATA_W-1:0] data_sram_wdata;
  logic              data_sram_addr_ok;
  logic              data_sram_data_ok;
  logic [DATA_W-1:0] data_sram_rdata;

  modport master (
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );

  modport slave (
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );
endinterface

// File: rtl/dsram_req_ctrl_resp_fifo.sv
// ---------------------------------------------------------------------------
// dsram_req_ctrl_resp_fifo
// Small in-order response FIFO with a synchronous clear. The head entry is
// visible combinationally so MEM sees the response in the cycle valid_o is
// high. A clear wins over push and pop in the same cycle.
// Ports:
//   clk, resetn  : clock, asynchronous active-low reset
//   clr_i        : drop all entries
//   push_i       : write push_data_i at the tail
//   pop_i        : remove the head (ignored when empty)
//   valid_o      : FIFO non-empty
//   head_o       : head entry, zero when empty
//   count_o      : number of stored entries
// ---------------------------------------------------------------------------
module dsram_req_ctrl_resp_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 33,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign valid_o = (count_q != '0);
  assign count_o = count_q;
  assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;

  assign pop_ok  = pop_i && !clr_i && valid_o;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = push_i && !clr_i && ((count_q != CNT_W'(DEPTH)) || pop_ok);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage has no reset; entries are only observable once written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  overflow_a: assert property (@(posedge clk) disable iff (!resetn)
    !(push_i && !clr_i && (count_q == CNT_W'(DEPTH)) && !pop_ok));

endmodule

// File: rtl/dsram_req_ctrl.sv
// ---------------------------------------------------------------------------
// dsram_req_ctrl
// Sequences data-SRAM accesses for the load/store pipe. One request is
// latched from EXE, presented on the SRAM-like bus until addr_ok, and its
// data phase is tracked until data_ok. Responses are buffered in order for
// MEM. A flush turns every live in-flight transaction into a "discard"
// whose data_ok is swallowed without reaching the response FIFO.
// Ports:
//   clk, resetn : clock, asynchronous active-low reset
//   pipe        : dsram_pipe_if.slave (EXE request, flush, MEM response)
//   bus         : dsram_sram_if.master (SRAM-like data bus)
// ---------------------------------------------------------------------------
module dsram_req_ctrl
  import dsram_req_ctrl_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = 2
) (
  input  logic         clk,
  input  logic         resetn,
  dsram_pipe_if.slave  pipe,
  dsram_sram_if.master bus
);

  localparam int FCNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int SUM_W  = CNT_W + 3;

  state_e            state_q, state_d;
  logic              wr_q, wr_d;
  logic [SIZE_W-1:0] size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              cancel_q, cancel_d;
  logic [CNT_W-1:0]  outst_q, outst_d;
  logic [CNT_W-1:0]  disc_q, disc_d;

  // wr flag of each live in-flight transaction, oldest in bit 0.
  logic [MAX_OUTSTANDING-1:0] wrq_q, wrq_d, wrq_shift;
  logic [CNT_W-1:0]           push_idx;

  logic             req_ready_c;
  logic [SUM_W-1:0] credit_sum;
  logic             credit_ok;
  logic             addr_fire;
  logic             data_to_disc, data_to_live;
  logic             live_push, live_pop;

  logic              fifo_push, fifo_pop, fifo_valid;
  logic [FCNT_W-1:0] fifo_cnt;
  logic [DATA_W:0]   fifo_head;

  // Every transaction that could still produce a response holds a credit,
  // including the one waiting for addr_ok, so the FIFO can never overfill.
  assign credit_sum = SUM_W'(outst_q) + SUM_W'(disc_q) + SUM_W'(fifo_cnt)
                    + SUM_W'(state_q == ST_REQ);
  assign credit_ok  = credit_sum < SUM_W'(MAX_OUTSTANDING);

  assign addr_fire    = (state_q == ST_REQ) && bus.data_sram_addr_ok;
  // Discarded transactions are always older than live ones, so data_ok
  // retires discards first.
  assign data_to_disc = bus.data_sram_data_ok && (disc_q != '0);
  assign data_to_live = bus.data_sram_data_ok && (disc_q == '0);
  assign live_push    = addr_fire && !cancel_q && !pipe.flush;
  assign live_pop     = data_to_live && !pipe.flush;

  // ---------------- request FSM ----------------
  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    size_d      = size_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    cancel_d    = cancel_q;
    req_ready_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready_c = credit_ok && !pipe.flush;
        if (pipe.req_valid && req_ready_c) begin
          wr_d     = pipe.req_wr;
          size_d   = pipe.req_size;
          addr_d   = pipe.req_addr;
          wdata_d  = gen_wdata(pipe.req_size, pipe.req_wdata);
          wstrb_d  = gen_wstrb(pipe.req_wr, pipe.req_size, pipe.req_addr[1:0]);
          cancel_d = 1'b0;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        // The bus does not allow withdrawing req, so a flush only marks
        // the pending transaction as cancelled.
        if (pipe.flush) cancel_d = 1'b1;
        if (bus.data_sram_addr_ok) begin
          cancel_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- outstanding / discard counters ----------------
  always_comb begin
    outst_d = outst_q;
    disc_d  = disc_q;
    if (pipe.flush) begin
      // Everything alive, plus an address accepted this cycle, becomes a
      // discard; a data_ok in this cycle retires one of them.
      outst_d = '0;
      disc_d  = disc_q + outst_q + CNT_W'(addr_fire) - CNT_W'(bus.data_sram_data_ok);
    end else begin
      disc_d  = disc_q + CNT_W'(addr_fire && cancel_q) - CNT_W'(data_to_disc);
      outst_d = outst_q + CNT_W'(addr_fire && !cancel_q) - CNT_W'(data_to_live);
    end
  end

  // ---------------- wr tracking of live transactions ----------------
  assign wrq_shift = live_pop ? (wrq_q >> 1) : wrq_q;
  assign push_idx  = outst_q - CNT_W'(live_pop);

  for (genvar gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_wrq
    assign wrq_d[gi] = (live_push && (push_idx == CNT_W'(gi))) ? wr_q : wrq_shift[gi];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      wr_q     <= 1'b0;
      size_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      cancel_q <= 1'b0;
      outst_q  <= '0;
      disc_q   <= '0;
      wrq_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      cancel_q <= cancel_d;
      outst_q  <= outst_d;
      disc_q   <= disc_d;
      wrq_q    <= wrq_d;
    end
  end

  // ---------------- response FIFO ----------------
  assign fifo_push = live_pop;
  assign fifo_pop  = fifo_valid && pipe.resp_ready;

  dsram_req_ctrl_resp_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (DATA_W + 1)
  ) u_resp_fifo (
    .clk         (clk),
    .resetn      (resetn),
    .clr_i       (pipe.flush),
    .push_i      (fifo_push),
    .push_data_i ({wrq_q[0], bus.data_sram_rdata}),
    .pop_i       (fifo_pop),
    .valid_o     (fifo_valid),
    .head_o      (fifo_head),
    .count_o     (fifo_cnt)
  );

  // ---------------- outputs ----------------
  // req_ready is gated by resetn so nothing looks acceptable during reset.
  assign pipe.req_ready  = resetn && req_ready_c;
  assign pipe.resp_valid = fifo_valid;
  assign pipe.resp_wr    = fifo_head[DATA_W];
  assign pipe.resp_rdata = fifo_head[DATA_W-1:0];

  assign bus.data_sram_req   = (state_q == ST_REQ);
  assign bus.data_sram_wr    = wr_q;
  assign bus.data_sram_size  = size_q;
  assign bus.data_sram_addr  = addr_q;
  assign bus.data_sram_wdata = wdata_q;
  assign bus.data_sram_wstrb = wstrb_q;

  data_ok_underflow_a: assert property (@(posedge clk) disable iff (!resetn)
    !(bus.data_sram_data_ok && (outst_q == '0) && (disc_q == '0)));

  illegal_size_a: assert property (@(posedge clk) disable iff (!resetn)
    !(pipe.req_valid && pipe.req_ready && (pipe.req_size == 2'd3)));

endmodule
